// File: rtl/io_1_output_serializer_pkg.sv
// Shared definitions for the IO-tile output serializer and its pad neighbours.
`timescale 1ns/1ps
package io_1_output_serializer_pkg;

    // Frame state of the serializer
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // Tristate polarity shared with the bidirectional pad BEL: 1 releases the pad
    localparam logic TRI_RELEASE = 1'b1;
    localparam logic TRI_DRIVE   = ~TRI_RELEASE;

    // Bits needed by the per-frame bit counter
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/io_piso_shift.sv
// Parallel-load, MSB-first shift register with load and shift enables.
`timescale 1ns/1ps
module io_piso_shift
    import io_1_output_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = 9
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_shift,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_sout
);

    logic [WIDTH-1:0] r_sr;

    // Load has priority over shift; zeros fill from the LSB end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sr <= '0;
        end else if (i_load) begin
            r_sr <= i_data;
        end else if (i_shift) begin
            r_sr <= {r_sr[WIDTH-2:0], 1'b0};
        end
    end

    assign o_sout = r_sr[WIDTH-1];

endmodule

// File: rtl/io_1_output_serializer.sv
// Fabric-to-pad output BEL: accepts a parallel word with valid/ready and
// shifts it out on I_top (optional start bit, then data MSB-first) while
// driving the pad through T_top for the duration of the frame.
`timescale 1ns/1ps
module io_1_output_serializer
    import io_1_output_serializer_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned START_BIT  = 1,
    parameter bit          IDLE_LEVEL = 1'b1,
    parameter bit          DRIVE_IDLE = 1'b0
) (
    input  logic             UserCLK,
    input  logic             UserRST,
    input  logic             OutputEnable,
    input  logic [WIDTH-1:0] D,
    input  logic             D_valid,
    output logic             D_ready,
    output logic             Busy,
    output logic             Done,
    output logic             I_top,
    output logic             T_top
);

    localparam int unsigned     FW       = WIDTH + START_BIT;
    localparam int              CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(FW - 1);

    state_t          r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic            r_itop, w_itop_nxt;
    logic            r_drive, w_drive_nxt;
    logic            r_done, w_done_nxt;
    logic            w_ready, w_accept, w_load, w_shift, w_sout;
    logic [FW-1:0]   w_frame;
    logic [FW-1:0]   w_load_word;

    // Zero-extension places the start bit (0) in front of the data when enabled
    assign w_frame     = FW'(D);
    // The first frame bit goes straight to I_top; the register keeps the rest
    assign w_load_word = {w_frame[FW-2:0], 1'b0};

    io_piso_shift #(
        .WIDTH (FW)
    ) u_piso (
        .i_clk   (UserCLK),
        .i_rst   (UserRST),
        .i_load  (w_load),
        .i_shift (w_shift),
        .i_data  (w_load_word),
        .o_sout  (w_sout)
    );

    // Next-state, counter, output-bit and handshake decisions
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_itop_nxt  = r_itop;
        w_drive_nxt = r_drive;
        w_done_nxt  = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_ready     = OutputEnable &&
                      ((r_state == ST_IDLE) || ((r_state == ST_SHIFT) && (r_cnt == '0)));
        w_accept    = D_valid && w_ready;

        case (r_state)
            ST_IDLE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_SHIFT: begin
                if (!OutputEnable) begin
                    // Abort: partial frame dropped, no completion pulse
                    w_state_nxt = ST_IDLE;
                    w_itop_nxt  = IDLE_LEVEL;
                    w_drive_nxt = DRIVE_IDLE;
                end else if (r_cnt != '0) begin
                    w_shift     = 1'b1;
                    w_itop_nxt  = w_sout;
                    w_cnt_nxt   = r_cnt - CW'(1);
                end else begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_itop_nxt  = IDLE_LEVEL;
                    w_drive_nxt = DRIVE_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // A new word overrides the end-of-frame return to idle (no gap)
        if (w_accept) begin
            w_load      = 1'b1;
            w_state_nxt = ST_SHIFT;
            w_cnt_nxt   = CNT_LAST;
            w_itop_nxt  = w_frame[FW-1];
            w_drive_nxt = 1'b1;
        end
    end

    // State and output registers
    always_ff @(posedge UserCLK or posedge UserRST) begin
        if (UserRST) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_itop  <= IDLE_LEVEL;
            r_drive <= DRIVE_IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_itop  <= w_itop_nxt;
            r_drive <= w_drive_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign D_ready = w_ready;
    assign Busy    = (r_state == ST_SHIFT);
    assign Done    = r_done;
    assign I_top   = r_itop;
    // Combinational so that dropping OutputEnable releases the pad at once
    assign T_top   = (r_drive && OutputEnable) ? TRI_DRIVE : TRI_RELEASE;

endmodule

// File: tb/tb_io_1_output_serializer.sv
// Bench for io_1_output_serializer: two instances (start bit / released idle,
// and no start bit / driven idle) share one stimulus stream and are checked
// every cycle against a frame-position model, plus literal expectations.
`timescale 1ns/1ps
module tb_io_1_output_serializer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       oe  = 1'b0;
    logic       dv  = 1'b0;
    logic [7:0] d   = 8'h00;

    logic ready0, busy0, done0, i0, t0;
    logic ready1, busy1, done1, i1, t1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    io_1_output_serializer #(
        .WIDTH(8), .START_BIT(1), .IDLE_LEVEL(1'b1), .DRIVE_IDLE(1'b0)
    ) dut0 (
        .UserCLK(clk), .UserRST(rst), .OutputEnable(oe), .D(d), .D_valid(dv),
        .D_ready(ready0), .Busy(busy0), .Done(done0), .I_top(i0), .T_top(t0)
    );

    io_1_output_serializer #(
        .WIDTH(8), .START_BIT(0), .IDLE_LEVEL(1'b1), .DRIVE_IDLE(1'b1)
    ) dut1 (
        .UserCLK(clk), .UserRST(rst), .OutputEnable(oe), .D(d), .D_valid(dv),
        .D_ready(ready1), .Busy(busy1), .Done(done1), .I_top(i1), .T_top(t1)
    );

    logic a_rdy [2];
    logic a_bsy [2];
    logic a_dn  [2];
    logic a_i   [2];
    logic a_t   [2];
    assign a_rdy[0] = ready0; assign a_rdy[1] = ready1;
    assign a_bsy[0] = busy0;  assign a_bsy[1] = busy1;
    assign a_dn[0]  = done0;  assign a_dn[1]  = done1;
    assign a_i[0]   = i0;     assign a_i[1]   = i1;
    assign a_t[0]   = t0;     assign a_t[1]   = t1;

    localparam int ST   [2] = '{1, 0};
    localparam int DRVI [2] = '{0, 1};

    // Model: frame is active, m_pos is the index of the bit now on the pad
    bit         m_act  [2];
    int         m_pos  [2];
    logic [7:0] m_d    [2];
    bit         m_done [2];

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input int k);
        int idx;
        if (ST[k] == 1 && m_pos[k] == 0) return 1'b0;
        idx = 7 - (m_pos[k] - ST[k]);
        return m_d[k][idx];
    endfunction

    function automatic logic last_pos(input int k);
        return m_pos[k] == 7 + ST[k];
    endfunction

    function automatic logic exp_ready(input int k);
        return oe && (!m_act[k] || last_pos(k));
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                m_act[k] = 1'b0; m_pos[k] = 0; m_d[k] = 8'h00; m_done[k] = 1'b0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit acc;
                acc = dv && exp_ready(k);
                m_done[k] = 1'b0;
                if (m_act[k]) begin
                    if (!oe) begin
                        m_act[k] = 1'b0;
                    end else if (last_pos(k)) begin
                        m_done[k] = 1'b1;
                        m_act[k]  = 1'b0;
                    end else begin
                        m_pos[k]++;
                    end
                end
                if (acc) begin
                    m_act[k] = 1'b1; m_pos[k] = 0; m_d[k] = d;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                logic drv;
                drv = m_act[k] ? 1'b1 : DRVI[k][0];
                chk($sformatf("i_top%0d", k), a_i[k], m_act[k] ? exp_bit(k) : 1'b1);
                chk($sformatf("busy%0d", k), a_bsy[k], m_act[k]);
                chk($sformatf("done%0d", k), a_dn[k], m_done[k]);
                chk($sformatf("ready%0d", k), a_rdy[k], exp_ready(k));
                chk($sformatf("t_top%0d", k), a_t[k], !(drv && oe));
            end
        end
    end

    task automatic drive(input bit o, input bit v, input logic [7:0] dd);
        @(posedge clk);
        #1;
        oe = o; dv = v; d = dd;
    endtask

    initial begin
        logic [8:0] a5_seq;
        logic [7:0] c3_seq;
        int drv_n, dn_n, rdy_n;
        a5_seq = 9'b010100101;
        c3_seq = 8'b00111100;

        // Reset asserted mid-cycle
        #3 rst = 1'b1;
        #1;
        chk("rst_i_top", i0, 1'b1);
        chk("rst_t_top", t0, 1'b1);
        chk("rst_ready", ready0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_done", done0, 1'b0);
        chk_en = 1'b1;
        @(posedge clk); #4 rst = 1'b0;
        #1 chk("ready_oe0", ready0, 1'b0);
        drive(1'b1, 1'b0, 8'h00);
        #1 chk("ready_oe1", ready0, 1'b1);

        // Single frame 8'hA5
        drive(1'b1, 1'b1, 8'hA5);
        drive(1'b1, 1'b0, 8'hA5);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk($sformatf("a5_bit%0d", i), i0, a5_seq[8-i]);
            chk($sformatf("a5_t%0d", i), t0, 1'b0);
        end
        @(negedge clk);
        chk("a5_done", done0, 1'b1);
        chk("a5_t_end", t0, 1'b1);
        chk("a5_i_end", i0, 1'b1);

        // Back-to-back 8'hFF then 8'h00
        repeat (2) drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 8'hFF);
        drive(1'b1, 1'b1, 8'h00);
        drv_n = 0; dn_n = 0; rdy_n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (t0 == 1'b0) drv_n++;
            if (done0) dn_n++;
            if (i < 17 && ready0) rdy_n++;
            if (i == 8) begin
                @(posedge clk); #1 dv = 1'b0;
            end
        end
        total++; if (drv_n != 18) begin bad++; $display("FAIL b2b_driven got=%0d want=18", drv_n); end
        total++; if (dn_n != 2) begin bad++; $display("FAIL b2b_done got=%0d want=2", dn_n); end
        total++; if (rdy_n != 1) begin bad++; $display("FAIL b2b_ready got=%0d want=1", rdy_n); end

        // Abort at bit 4
        repeat (2) drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 8'h55);
        drive(1'b1, 1'b0, 8'h55);
        repeat (4) @(posedge clk);
        #1 oe = 1'b0;
        #1;
        chk("abort_t_now", t0, 1'b1);
        chk("abort_busy_now", busy0, 1'b1);
        @(posedge clk); #1;
        chk("abort_i_next", i0, 1'b1);
        chk("abort_busy_next", busy0, 1'b0);
        chk("abort_done_next", done0, 1'b0);
        @(posedge clk); #1;
        chk("abort_no_done", done0, 1'b0);

        // Driven idle, no start bit: 8'h3C on the second instance
        repeat (3) drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 8'h3C);
        drive(1'b1, 1'b0, 8'h3C);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("3c_bit%0d", i), i1, c3_seq[7-i]);
            chk($sformatf("3c_t%0d", i), t1, 1'b0);
        end
        @(negedge clk);
        chk("3c_i_end", i1, 1'b1);
        chk("3c_t_idle", t1, 1'b0);

        // Reset mid-frame at bit 3, then a full fresh frame
        repeat (3) drive(1'b1, 1'b0, 8'h00);
        drive(1'b1, 1'b1, 8'hC3);
        drive(1'b1, 1'b0, 8'hC3);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mrst_i_top", i0, 1'b1);
        chk("mrst_busy", busy0, 1'b0);
        chk("mrst_t_top", t0, 1'b1);
        @(negedge clk);
        #2 rst = 1'b0;
        drive(1'b1, 1'b1, 8'h81);
        drive(1'b1, 1'b0, 8'h81);
        @(negedge clk);
        chk("restart_start", i0, 1'b0);
        @(negedge clk);
        chk("restart_msb", i0, 1'b1);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 15) != 0, $urandom_range(0, 2) == 0, 8'($urandom));
        end
        repeat (12) drive(1'b1, 1'b0, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_1_output_serializer.md
Name: io_1_output_serializer

Overview:
- Fabric-to-pad output BEL; the transmit counterpart of the registered pad-input path (pad→FF→Q).
- Accepts a parallel word from the switch matrix with a valid/ready handshake and shifts it out serially on I_top.
- Drives the tristate control T_top for the duration of each frame.
- Sits in IO tiles next to the bidirectional pad BEL; I_top and T_top are EXTERNAL and route to the top-level entity.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..32.
- START_BIT, 1, when 1 a single start bit (value 0) precedes the data bits.
- IDLE_LEVEL, 1, value of I_top when no frame is active.
- DRIVE_IDLE, 0, when 1 the pad stays driven (T_top=0) while idle; when 0 the pad is released (T_top=1).

Ports:
- UserCLK  input  1  user clock; EXTERNAL, SHARED_PORT.
- UserRST  input  1  asynchronous, active-high reset.
- OutputEnable  input  1  global enable; EXTERNAL, SHARED_PORT. Low means configuration is in progress.
- D  input  WIDTH  parallel data from fabric.
- D_valid  input  1  D holds a word to send.
- D_ready  output  1  block can accept a word this cycle.
- Busy  output  1  a frame is in flight.
- Done  output  1  one-cycle pulse after the last bit of a frame.
- I_top  output  1  serial data to pad.
- T_top  output  1  tristate control to pad; 1 means pad released (high-Z).

Behaviour:
- Reset: asynchronous on UserRST=1. Values while reset is held:
  - state=IDLE, shift register=0, bit counter=0.
  - I_top=IDLE_LEVEL, Done=0, Busy=0, drive flag=DRIVE_IDLE.
- Tristate output: T_top = ~drive_q | ~OutputEnable. This is combinational, so OutputEnable=0 releases the pad immediately.
- D_ready = OutputEnable & ((state==IDLE) | (state==SHIFT & cnt==0)). Combinational.
- Accept occurs on a rising edge where D_valid & D_ready.
  - D is captured into the shift register.
  - Frame length is N = WIDTH + START_BIT bits.
  - cnt is loaded with N-1.
  - state goes to SHIFT and drive_q goes to 1.
- Bit order: start bit first (if enabled), then data MSB-first.
- Output timing:
  - I_top is registered and shows the first bit from the accepting edge.
  - Each bit is held exactly one UserCLK cycle.
- SHIFT state: on each edge with cnt>0, present the next bit and decrement cnt.
- End of frame (edge with cnt==0):
  - If a new word is accepted on the same edge, load it with no gap. Done still pulses for the completed frame.
  - Otherwise: state goes to IDLE, I_top=IDLE_LEVEL, drive_q=DRIVE_IDLE, Done=1 for one cycle.
- Busy = (state==SHIFT). Registered.
- Abort: OutputEnable=0 during SHIFT.
  - Next edge: state goes to IDLE, I_top=IDLE_LEVEL, drive_q=DRIVE_IDLE.
  - No Done pulse; any partial frame is discarded.
- OutputEnable=0 in IDLE: no accept, because D_ready=0.
- D and D_valid are ignored when D_ready=0; no queuing.
- Reset during SHIFT: immediate return to the reset values; I_top=IDLE_LEVEL asynchronously.

Decomposition:
- Shared package/header holds:
  - State encoding: IDLE=0, SHIFT=1.
  - Counter width function clog2(WIDTH+1).
  - The tristate polarity constant (1=release), shared with the bidirectional pad BEL.
- One natural sub-module, io_piso_shift: parallel-load, MSB-first, parameterised-width shift register with load/shift enables. The FSM, counter and handshake stay in the top.

Test Plan:
- Reset: assert UserRST mid-cycle → I_top=1, T_top=1, D_ready=0 until OutputEnable=1, after which D_ready=1; Busy=0, Done=0.
- Single frame (WIDTH=8, START_BIT=1, OutputEnable=1), D=8'hA5 with D_valid one cycle:
  - I_top sequence 0,1,0,1,0,0,1,0,1 over 9 cycles.
  - T_top=0 for those 9 cycles, then 1.
  - Done pulses on cycle 10.
- Back-to-back: D_valid held high with 8'hFF then 8'h00 → 18 contiguous driven cycles, no idle gap, two Done pulses, D_ready high only on cycles 0 and 9.
- Abort: drop OutputEnable at bit 4 of a frame → T_top=1 in the same cycle, I_top=1 next edge, no Done pulse, Busy=0 next edge.
- DRIVE_IDLE=1, START_BIT=0, D=8'h3C → T_top=0 throughout, including idle; I_top=0,0,1,1,1,1,0,0 then 1.
- Reset mid-frame (bit 3) → I_top=1 and Busy=0 asynchronously; the next accepted word transmits a full frame from the start bit.
